// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register round-robin arbiter.
package shared_reg_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;
  localparam int WRITE_CNT_W = 16;
endpackage

// File: rtl/shared_reg_arbiter_load_reg.sv
// DATA_W-wide D register with synchronous active-high reset and load enable.
module load_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of one shared register, with hold-time preemption.
// Optional macro SHARED_REG_WRITE_CNT_EN adds a 16-bit wrapping load counter output.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic [ID_W-1:0]           owner_id,
`ifdef SHARED_REG_WRITE_CNT_EN
  output logic [WRITE_CNT_W-1:0]    write_cnt,
`endif
  output logic [DATA_W-1:0]         q
);
  localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_busy;
  logic [ID_W-1:0]     r_owner;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [HC_W-1:0]     r_hold_cnt;

  logic                w_load;
  logic                w_owner_req;
  logic                w_others;
  logic [ID_W-1:0]     w_pick;
  logic [ID_W-1:0]     w_next_ptr;
  logic [DATA_W-1:0]   w_sel_data;

  // Lowest circular distance from ptr wins; scanning downward lets the nearest overwrite.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [ID_W-1:0] ptr);
    int idx;
    rr_pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (r[idx]) rr_pick = ID_W'(idx);
    end
  endfunction

  assign w_pick      = rr_pick(req, r_rr_ptr);
  assign w_owner_req = req[r_owner];
  assign w_others    = |(req & ~r_gnt);
  assign w_next_ptr  = (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + ID_W'(1);
  assign w_sel_data  = wdata[int'(r_owner)*DATA_W +: DATA_W];
  assign w_load      = (r_state == ST_OWN) && w_owner_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_busy     <= 1'b0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_state    <= ST_OWN;
            r_gnt      <= NUM_REQ'(1) << w_pick;
            r_busy     <= 1'b1;
            r_owner    <= w_pick;
            r_hold_cnt <= '0;
          end
        end
        ST_OWN: begin
          // Preemption edge still loads; the release edge does not (w_load covers both).
          if (!w_owner_req || (r_hold_cnt == HOLD_LAST && w_others)) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_next_ptr;
          end else if (r_hold_cnt != HOLD_LAST) begin
            r_hold_cnt <= r_hold_cnt + HC_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  load_reg #(.DATA_W(DATA_W)) u_load_reg (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_d    (w_sel_data),
    .o_q    (q)
  );

`ifdef SHARED_REG_WRITE_CNT_EN
  logic [WRITE_CNT_W-1:0] r_write_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_write_cnt <= '0;
    else if (w_load) r_write_cnt <= r_write_cnt + WRITE_CNT_W'(1);
  end

  assign write_cnt = r_write_cnt;
`endif

  assign gnt      = r_gnt;
  assign busy     = r_busy;
  assign owner_id = r_owner;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (NUM_REQ=4, DATA_W=8, MAX_HOLD=4).
module tb_shared_reg_arbiter;
  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        busy;
  logic [1:0]  owner_id;
  logic [7:0]  q;
`ifdef SHARED_REG_WRITE_CNT_EN
  logic [15:0] write_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  shared_reg_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .busy     (busy),
    .owner_id (owner_id),
`ifdef SHARED_REG_WRITE_CNT_EN
    .write_cnt(write_cnt),
`endif
    .q        (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    wdata = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    wdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if ({gnt, busy, q, owner_id} !== {4'b0, 1'b0, 8'h00, 2'd0}) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: gnt=%b busy=%b q=%h owner=%0d, want 0000 0 00 0",
                 c, gnt, busy, q, owner_id);
      end
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_release_gnt: got %b want 0001", gnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    wdata[16 +: 8] = 8'hA5;
    tick();
    n_tests++;
    if (gnt !== 4'b0100 || busy !== 1'b1 || owner_id !== 2'd2) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b busy=%b owner=%0d want 0100 1 2", gnt, busy, owner_id);
    end
    tick();
    n_tests++;
    if (q !== 8'hA5 || gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_load: q=%h gnt=%b want a5 0100", q, gnt);
    end
    tick();
    n_tests++;
    if (gnt !== 4'b0100 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_hold3: gnt=%b busy=%b want 0100 1", gnt, busy);
    end
    req = 4'b0000;
    tick();
    n_tests++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_release: gnt=%b busy=%b q=%h want 0000 0 a5", gnt, busy, q);
    end
    req = 4'b1111;
    tick();
    n_tests++;
    if (gnt !== 4'b1000 || owner_id !== 2'd3) begin
      n_fail++;
      $display("FAIL single_next_ptr: gnt=%b owner=%0d want 1000 3", gnt, owner_id);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [4];
    logic [3:0] oh;
    order = '{2'd0, 2'd1, 2'd3, 2'd0};
    do_reset();
    req = 4'b1011;
    for (int g = 0; g < 4; g++) begin
      oh = 4'b0001 << order[g];
      tick();
      n_tests++;
      if (gnt !== oh || owner_id !== order[g] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant%0d: gnt=%b owner=%0d busy=%b want %b %0d 1",
                 g, gnt, owner_id, busy, oh, order[g]);
      end
      req = 4'b1011 & ~oh;
      tick();
      n_tests++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_idle%0d: gnt=%b busy=%b want 0000 0", g, gnt, busy);
      end
      req = 4'b1011;
    end
  endtask

  task automatic test_preempt();
    do_reset();
    req = 4'b0001;
    tick();
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL pre_grant: gnt=%b want 0001", gnt);
    end
    for (int k = 0; k < 4; k++) begin
      wdata[7:0] = 8'h10 + 8'(k);
      if (k == 1) req = 4'b0011;
      tick();
      n_tests++;
      if (q !== 8'h10 + 8'(k)) begin
        n_fail++;
        $display("FAIL pre_load%0d: q=%h want %h", k, q, 8'h10 + 8'(k));
      end
      if (k == 2) begin
        n_tests++;
        if (gnt !== 4'b0001) begin
          n_fail++;
          $display("FAIL pre_still_owned: gnt=%b want 0001", gnt);
        end
      end
    end
    n_tests++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_idle: gnt=%b busy=%b want 0000 0", gnt, busy);
    end
    wdata[7:0] = 8'h15;
    tick();
    n_tests++;
    if (gnt !== 4'b0010 || q !== 8'h13) begin
      n_fail++;
      $display("FAIL pre_next: gnt=%b q=%h want 0010 13", gnt, q);
    end
  endtask

  task automatic test_unopposed();
    do_reset();
    req = 4'b0100;
    wdata[16 +: 8] = 8'h5A;
    tick();
    for (int c = 0; c < 6; c++) tick();
    n_tests++;
    if (gnt !== 4'b0100 || q !== 8'h5A) begin
      n_fail++;
      $display("FAIL unopp_hold: gnt=%b q=%h want 0100 5a", gnt, q);
    end
    req = 4'b0110;
    wdata[16 +: 8] = 8'h66;
    tick();
    n_tests++;
    if (gnt !== 4'b0000 || q !== 8'h66) begin
      n_fail++;
      $display("FAIL unopp_late_preempt: gnt=%b q=%h want 0000 66", gnt, q);
    end
    tick();
    n_tests++;
    if (gnt !== 4'b0010 || owner_id !== 2'd1) begin
      n_fail++;
      $display("FAIL unopp_next: gnt=%b owner=%0d want 0010 1", gnt, owner_id);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010;
    wdata[15:8] = 8'h3C;
    tick();
    n_tests++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_grant: gnt=%b want 0010", gnt);
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if (q !== 8'h00 || gnt !== 4'b0000 || busy !== 1'b0 || owner_id !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset: q=%h gnt=%b busy=%b owner=%0d want 00 0000 0 0",
               q, gnt, busy, owner_id);
    end
    reset = 1'b0;
    req   = 4'b0000;
  endtask

`ifdef SHARED_REG_WRITE_CNT_EN
  task automatic test_write_cnt();
    do_reset();
    req = 4'b0001;
    tick();
    for (int c = 0; c < 65537; c++) tick();
    n_tests++;
    if (write_cnt !== 16'h0001) begin
      n_fail++;
      $display("FAIL write_cnt_wrap: got %h want 0001", write_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req   = '0;
    wdata = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_unopposed();
    test_reset_mid();
`ifdef SHARED_REG_WRITE_CNT_EN
    test_write_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
